// File: rtl/hc21_ste_requester.sv
// hc21_ste_requester
// Card-side STE backplane requester. It drives one attention request line
// for a local interrupt source. It also runs the bus-master
// request/acknowledge handshake on one STE bus request channel for a local
// DMA engine.
//
// Parameters:
//   ATN_LEVEL      - atnrq_n bit driven by this card (0..7, 0 = NMI)
//   BUS_CHAN       - busrq_n/busak_n pair used (0..1)
//   TIMEOUT_CYCLES - acknowledge wait limit (1..255); 0 disables the timeout
//
// Ports:
//   sysclk, sysrst_n - clock, asynchronous active-low reset
//   evt, evt_clr     - interrupt event pulse / ISR service strobe
//   atnrq_n[7:0]     - attention request lines (0 = asserted)
//   irq_pending      - attention request currently asserted
//   evt_overrun      - sticky: event seen while already pending
//   dma_req          - local engine wants bus mastership (level)
//   dma_done         - local engine finished (pulse, used while owning)
//   busrq_n[1:0]     - bus request lines (0 = asserted)
//   busak_n[1:0]     - bus acknowledge lines (asynchronous)
//   dma_grant        - local engine owns the bus
//   dma_timeout      - one-cycle pulse on acknowledge timeout
//
// Build option:
//   HC21_BUSAK_SYNC_EN - defined: two-flop synchroniser on busak_n;
//                        undefined: single register stage.
module hc21_ste_requester #(
    parameter int unsigned ATN_LEVEL      = 3,
    parameter int unsigned BUS_CHAN       = 0,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic       sysclk,
    input  logic       sysrst_n,
    input  logic       evt,
    input  logic       evt_clr,
    output logic [7:0] atnrq_n,
    output logic       irq_pending,
    output logic       evt_overrun,
    input  logic       dma_req,
    input  logic       dma_done,
    output logic [1:0] busrq_n,
    input  logic [1:0] busak_n,
    output logic       dma_grant,
    output logic       dma_timeout
);

    localparam logic [7:0] ATN_MASK  = 8'(1 << ATN_LEVEL);
    localparam logic [1:0] CHAN_MASK = 2'(1 << BUS_CHAN);
    localparam logic [7:0] TO_LIM    = 8'(TIMEOUT_CYCLES);
    localparam logic       TO_EN     = (TIMEOUT_CYCLES != 0);

    typedef enum logic [1:0] {IDLE, REQ, OWN, REL} state_t;

    state_t     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic       pend_q, pend_d;
    logic       ovr_q, ovr_d;
    logic       atn_n_q;
    logic       busrq_n_q, busrq_n_d;
    logic       grant_q, grant_d;
    logic       timeout_q, timeout_d;
    logic       ak;

    // Both acknowledge bits are registered; the channel is picked by mask.
`ifdef HC21_BUSAK_SYNC_EN
    logic [1:0] ak_meta_q, ak_sync_q;
    always_ff @(posedge sysclk or negedge sysrst_n) begin
        if (!sysrst_n) begin
            ak_meta_q <= '1;
            ak_sync_q <= '1;
        end else begin
            ak_meta_q <= busak_n;
            ak_sync_q <= ak_meta_q;
        end
    end
`else
    logic [1:0] ak_sync_q;
    always_ff @(posedge sysclk or negedge sysrst_n) begin
        if (!sysrst_n) ak_sync_q <= '1;
        else           ak_sync_q <= busak_n;
    end
`endif

    // ak = 1 while the selected acknowledge line is released
    assign ak = ~|(~ak_sync_q & CHAN_MASK);

    // Attention request: evt wins over evt_clr, and the pair clears overrun.
    always_comb begin
        pend_d = pend_q;
        ovr_d  = ovr_q;
        if (evt) begin
            pend_d = 1'b1;
            if (evt_clr)     ovr_d = 1'b0;
            else if (pend_q) ovr_d = 1'b1;
        end else if (evt_clr) begin
            pend_d = 1'b0;
            ovr_d  = 1'b0;
        end
    end

    // Bus request FSM
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        timeout_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (dma_req) begin
                    state_d = REQ;
                    cnt_d   = '0;
                end
            end
            REQ: begin
                if (!ak) begin
                    state_d = OWN;
                end else if (!dma_req) begin
                    state_d = REL;
                end else if (TO_EN && (cnt_q == TO_LIM)) begin
                    state_d   = REL;
                    timeout_d = 1'b1;
                end else if (cnt_q != '1) begin
                    // saturates so a disabled timeout never wraps
                    cnt_d = cnt_q + 8'd1;
                end
            end
            OWN: begin
                if (dma_done || !dma_req) state_d = REL;
            end
            REL: begin
                if (ak) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        busrq_n_d = ~((state_d == REQ) || (state_d == OWN));
        grant_d   = (state_d == OWN);
    end

    always_ff @(posedge sysclk or negedge sysrst_n) begin
        if (!sysrst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            pend_q    <= 1'b0;
            ovr_q     <= 1'b0;
            atn_n_q   <= 1'b1;
            busrq_n_q <= 1'b1;
            grant_q   <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pend_q    <= pend_d;
            ovr_q     <= ovr_d;
            atn_n_q   <= ~pend_d;
            busrq_n_q <= busrq_n_d;
            grant_q   <= grant_d;
            timeout_q <= timeout_d;
        end
    end

    // Unselected lines are tied released; selected lines come straight from flops.
    assign atnrq_n     = ~ATN_MASK | {8{atn_n_q}};
    assign busrq_n     = ~CHAN_MASK | {2{busrq_n_q}};
    assign irq_pending = pend_q;
    assign evt_overrun = ovr_q;
    assign dma_grant   = grant_q;
    assign dma_timeout = timeout_q;

endmodule
